// File: rtl/int_arbiter_if.sv
// Bundles the four-source interrupt request/handshake signals between the
// CPU-side environment (master) and the arbiter (slave).
interface int_arbiter_if;
    logic [3:0] int_req;
    logic [3:0] int_mask;
    logic       int_en;
    logic       int_ack;
    logic       intr;
    logic       ld;
    logic [3:0] data_out;
    logic [3:0] pending;

    modport master (
        output int_req,
        output int_mask,
        output int_en,
        output int_ack,
        input  intr,
        input  ld,
        input  data_out,
        input  pending
    );

    modport slave (
        input  int_req,
        input  int_mask,
        input  int_en,
        input  int_ack,
        output intr,
        output ld,
        output data_out,
        output pending
    );
endinterface

// File: rtl/int_arbiter.sv
// Interrupt front-end: synchronizes and edge-detects four request lines into
// sticky pending bits, picks the highest-priority enabled source and runs the
// intr/int_ack handshake, emitting a one-cycle load strobe with a one-hot ID.
module int_arbiter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         clr,
    int_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2,
        LOCKOUT = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] sel_q, sel_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] hist_q;
    logic [3:0] sync_out;
    logic [3:0] rise;
    logic [3:0] elig;
    logic [3:0] sel;
    logic [3:0] clear_mask;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_q;

            always_ff @(posedge clk) begin
                if (clr) begin
                    chain_q <= '0;
                end else begin
                    chain_q <= {chain_q[SYNC_STAGES-2:0], bus.int_req[gi]};
                end
            end

            assign sync_out[gi] = chain_q[SYNC_STAGES-1];
        end
    endgenerate

    assign rise       = sync_out & ~hist_q;
    assign elig       = pending_q & bus.int_mask;
    // Isolate the lowest set bit: bit 0 has the highest priority.
    assign sel        = elig & (~elig + 4'd1);
    assign clear_mask = (state_q == SERVICE) ? sel_q : 4'b0000;
    // A fresh edge must survive a same-cycle service clear.
    assign pending_d  = (pending_q & ~clear_mask) | rise;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (bus.int_en && (elig != 4'b0000)) begin
                    sel_d   = sel;
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (bus.int_ack) begin
                    state_d = SERVICE;
                end else if (!bus.int_en) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                state_d = LOCKOUT;
            end
            LOCKOUT: begin
                // Hold off re-entry until the CPU has visibly dropped its I flag.
                if (!bus.int_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            pending_q <= '0;
            hist_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            pending_q <= pending_d;
            hist_q    <= sync_out;
        end
    end

    assign bus.intr     = (state_q == ASSERT);
    assign bus.ld       = (state_q == SERVICE);
    assign bus.data_out = (state_q == SERVICE) ? sel_q : 4'b0000;
    assign bus.pending  = pending_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Directed walk through the handshake scenarios followed by random traffic,
// all checked every cycle against a delay-line/flag reference model.
module tb_int_arbiter;

    localparam int S = 2;

    logic clk;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    int_arbiter_if bus ();

    int_arbiter #(.SYNC_STAGES(S)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: samp[j] is int_req as sampled j+1 edges ago.
    logic [3:0] samp [0:S];
    logic [3:0] m_pend;
    logic [3:0] m_id;
    logic       m_intr;
    logic       m_ld;
    logic       m_lock;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [3:0] rise_m;
        logic [3:0] elig_m;
        logic [3:0] pick;
        logic [3:0] pend_next;
        if (clr) begin
            m_pend = 4'b0; m_id = 4'b0; m_intr = 1'b0; m_ld = 1'b0; m_lock = 1'b0;
            for (int j = 0; j <= S; j++) samp[j] = 4'b0;
            return;
        end
        rise_m    = samp[S-1] & ~samp[S];
        elig_m    = m_pend & bus.int_mask;
        pend_next = m_pend;
        if (m_ld) begin
            pend_next = pend_next & ~m_id;
            m_ld      = 1'b0;
            m_lock    = 1'b1;
        end else if (m_intr) begin
            if (bus.int_ack) begin
                m_intr = 1'b0;
                m_ld   = 1'b1;
            end else if (!bus.int_en) begin
                m_intr = 1'b0;
            end
        end else if (m_lock) begin
            if (!bus.int_en) m_lock = 1'b0;
        end else if (bus.int_en && elig_m != 4'b0) begin
            pick = 4'b0;
            for (int i = 0; i < 4; i++)
                if (elig_m[i] && pick == 4'b0) pick = 4'(1 << i);
            m_id   = pick;
            m_intr = 1'b1;
        end
        m_pend = pend_next | rise_m;
        for (int j = S; j > 0; j--) samp[j] = samp[j-1];
        samp[0] = bus.int_req;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("intr", {3'b0, bus.intr}, {3'b0, m_intr});
        chk("ld", {3'b0, bus.ld}, {3'b0, m_ld});
        chk("data_out", bus.data_out, m_ld ? m_id : 4'b0);
        chk("pending", bus.pending, m_pend);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        clr = 1'b1;
        bus.int_req = 4'b0; bus.int_mask = 4'b0; bus.int_en = 1'b0; bus.int_ack = 1'b0;
        for (int j = 0; j <= S; j++) samp[j] = 4'b0;
        m_pend = 4'b0; m_id = 4'b0; m_intr = 1'b0; m_ld = 1'b0; m_lock = 1'b0;
        steps(2);
        clr = 1'b0;
        chk("reset_pending", bus.pending, 4'b0000);
        chk("reset_intr", {3'b0, bus.intr}, 4'b0000);

        // Single source
        bus.int_en = 1'b1; bus.int_mask = 4'b1111; bus.int_req = 4'b0100;
        step();
        bus.int_req = 4'b0;
        steps(2);
        chk("single_pending", bus.pending, 4'b0100);
        step();
        chk("single_intr", {3'b0, bus.intr}, 4'b0001);
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        chk("single_ld", {3'b0, bus.ld}, 4'b0001);
        chk("single_id", bus.data_out, 4'b0100);
        step();
        chk("single_clear", bus.pending, 4'b0000);
        bus.int_en = 1'b0; step(); bus.int_en = 1'b1;

        // Priority and freeze, then lockout behaviour
        bus.int_req = 4'b1010; step(); bus.int_req = 4'b0;
        steps(3);
        bus.int_req = 4'b0001; step(); bus.int_req = 4'b0;
        steps(2);
        chk("freeze_pending", bus.pending, 4'b1011);
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        chk("freeze_id", bus.data_out, 4'b0010);
        steps(4);
        chk("lockout_intr", {3'b0, bus.intr}, 4'b0000);
        bus.int_en = 1'b0; step(); bus.int_en = 1'b1; step();
        chk("lockout_reassert", {3'b0, bus.intr}, 4'b0001);
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        chk("prio_id0", bus.data_out, 4'b0001);
        step();
        bus.int_en = 1'b0; step(); bus.int_en = 1'b1; step();
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        chk("prio_id3", bus.data_out, 4'b1000);
        step();
        bus.int_en = 1'b0; step(); bus.int_en = 1'b1;

        // Mask and withdraw
        bus.int_mask = 4'b1110; bus.int_req = 4'b0001; step(); bus.int_req = 4'b0;
        steps(4);
        chk("mask_intr", {3'b0, bus.intr}, 4'b0000);
        chk("mask_pending", bus.pending, 4'b0001);
        bus.int_mask = 4'b1111; step();
        bus.int_en = 1'b0; step();
        chk("withdraw_intr", {3'b0, bus.intr}, 4'b0000);
        chk("withdraw_pending", bus.pending, 4'b0001);
        bus.int_en = 1'b1; step();
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        step();
        bus.int_en = 1'b0; step(); bus.int_en = 1'b1;

        // Set/clear collision on source 2
        bus.int_req = 4'b0100; step(); bus.int_req = 4'b0;
        steps(3);
        bus.int_req = 4'b0100; step(); bus.int_req = 4'b0;
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        chk("collide_id", bus.data_out, 4'b0100);
        step();
        chk("collide_pending", bus.pending, 4'b0100);
        bus.int_en = 1'b0; step(); bus.int_en = 1'b1; step();
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        chk("collide_reservice", bus.data_out, 4'b0100);
        step();
        bus.int_en = 1'b0; step(); bus.int_en = 1'b1;

        // Reset mid-handshake
        bus.int_req = 4'b1010; step(); bus.int_req = 4'b0;
        steps(3);
        chk("rst_pre_intr", {3'b0, bus.intr}, 4'b0001);
        clr = 1'b1; step(); clr = 1'b0;
        chk("rst_pending", bus.pending, 4'b0000);
        chk("rst_intr", {3'b0, bus.intr}, 4'b0000);
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        chk("rst_no_ld", {3'b0, bus.ld}, 4'b0000);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            bus.int_req = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            bus.int_ack = ($urandom_range(0, 3) == 0);
            bus.int_en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) bus.int_mask = 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
